// File: rtl/logic_gate_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_gate_unit_pkg
//   Shared definitions for the WIDTH-bit bitwise logic unit and its gate core:
//   operation encodings, self-test FSM state encodings and a helper that sizes
//   the self-test sweep counter.
// -----------------------------------------------------------------------------
package logic_gate_unit_pkg;

  // Width of the runtime operation select.
  localparam int OP_W = 3;

  // Runtime operation encodings (values are part of the external interface).
  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,  // ~a, b ignored
    OP_PASS = 3'd7   //  a, b ignored
  } op_e;

  // Self-test sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // normal streaming operation
    ST_DRAIN = 2'd1,  // waiting for a pending result to be consumed
    ST_SWEEP = 2'd2,  // one self-test vector per cycle
    ST_DONE  = 2'd3   // single-cycle completion pulse
  } state_e;

  // Sweep counter width: op field on top, then operand a bits, then operand b
  // bits. Every combination is visited exactly once per sweep.
  function automatic int sweep_cnt_width(input int sweep_bits);
    return OP_W + 2 * sweep_bits;
  endfunction

endpackage : logic_gate_unit_pkg

// File: rtl/logic_gate_core.sv
// -----------------------------------------------------------------------------
// logic_gate_core
//   Purely combinational WIDTH-bit bitwise gate. Every bit position evaluates
//   the same selected operation on its own pair of operand bits.
//
//   Ports
//     op      in   3       operation select (op_e encoding)
//     a, b    in   WIDTH   operands
//     result  out  WIDTH   op(a, b), bitwise
// -----------------------------------------------------------------------------
module logic_gate_core
  import logic_gate_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  // One single-bit gate slice per bit; slices are independent so the whole
  // unit is a flat layer of identical LUT functions.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic bit_r;

    always_comb begin
      bit_r = 1'b0;
      case (op_e'(op))
        OP_AND:  bit_r =   a[gi] & b[gi];
        OP_OR:   bit_r =   a[gi] | b[gi];
        OP_NAND: bit_r = ~(a[gi] & b[gi]);
        OP_NOR:  bit_r = ~(a[gi] | b[gi]);
        OP_XOR:  bit_r =   a[gi] ^ b[gi];
        OP_XNOR: bit_r = ~(a[gi] ^ b[gi]);
        OP_NOT:  bit_r =  ~a[gi];
        OP_PASS: bit_r =   a[gi];
        default: bit_r = 1'b0;
      endcase
    end

    assign result[gi] = bit_r;
  end : g_bit

endmodule : logic_gate_core

// File: rtl/logic_gate_unit.sv
// -----------------------------------------------------------------------------
// logic_gate_unit
//   Registered WIDTH-bit bitwise logic unit with a valid/ready stream interface
//   (one-cycle latency, full throughput) and a built-in exhaustive self-test
//   sweep that folds every op / low-operand-bit combination into a rotating
//   XOR signature.
//
//   Parameters
//     WIDTH       operand/result width, >= 2
//     SWEEP_BITS  low operand bits exercised by the sweep, <= WIDTH
//                 (sweep length 8 * 4^SWEEP_BITS cycles)
//
//   Ports
//     clk          in   1      rising-edge clock
//     rst          in   1      asynchronous active-high reset
//     in_valid     in   1      operand beat valid
//     in_ready     out  1      beat accepted this cycle when in_valid is high
//     op           in   3      operation select (op_e encoding)
//     a, b         in   WIDTH  operands
//     out_valid    out  1      result valid
//     out_ready    in   1      consumer accepts result
//     y            out  WIDTH  registered result
//     y_zero       out  1      registered flag: y == 0
//     sweep_start  in   1      request a self-test sweep (honoured in IDLE)
//     sweep_busy   out  1      sweep in progress (DRAIN or SWEEP)
//     sweep_done   out  1      one-cycle pulse when the sweep completes
//     sweep_sig    out  WIDTH  sweep signature, held until the next sweep
// -----------------------------------------------------------------------------
module logic_gate_unit
  import logic_gate_unit_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SWEEP_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [WIDTH-1:0] sweep_sig
);

  localparam int CNT_W = sweep_cnt_width(SWEEP_BITS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] sig_q,       sig_d;
  logic [WIDTH-1:0] y_q,         y_d;
  logic             y_zero_q,    y_zero_d;
  logic             out_valid_q, out_valid_d;

  // ---------------------------------------------------------------------------
  // Sweep stimulus decoded from the counter and operand mux into the core
  // ---------------------------------------------------------------------------
  logic [OP_W-1:0]  sweep_op;
  logic [WIDTH-1:0] sweep_a;
  logic [WIDTH-1:0] sweep_b;
  logic [OP_W-1:0]  core_op;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] core_result;

  always_comb begin
    sweep_op = cnt_q[CNT_W-1 -: OP_W];
    // Zero-extend the low operand fields; written bit-range style so that
    // SWEEP_BITS == WIDTH needs no zero-width replication.
    sweep_a  = '0;
    sweep_b  = '0;
    sweep_a[SWEEP_BITS-1:0] = cnt_q[2*SWEEP_BITS-1:SWEEP_BITS];
    sweep_b[SWEEP_BITS-1:0] = cnt_q[SWEEP_BITS-1:0];
  end

  always_comb begin
    core_op = op;
    core_a  = a;
    core_b  = b;
    if (state_q == ST_SWEEP) begin
      core_op = sweep_op;
      core_a  = sweep_a;
      core_b  = sweep_b;
    end
  end

  logic_gate_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (core_op),
    .a      (core_a),
    .b      (core_b),
    .result (core_result)
  );

  // ---------------------------------------------------------------------------
  // Stream handshake and output register
  // ---------------------------------------------------------------------------
  logic accept_ok;
  logic load;

  // A new beat is taken whenever the output slot is empty or is being emptied
  // this very cycle, which gives back-to-back throughput without a skid buffer.
  assign accept_ok = (state_q == ST_IDLE) & (~out_valid_q | out_ready);
  assign load      = in_valid & accept_ok;

  always_comb begin
    y_d         = y_q;
    y_zero_d    = y_zero_q;
    out_valid_d = out_valid_q & ~out_ready;
    if (load) begin
      y_d         = core_result;
      y_zero_d    = (core_result == '0);
      out_valid_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Self-test sweep controller
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    case (state_q)
      ST_IDLE: begin
        if (sweep_start) begin
          state_d = ST_DRAIN;
          sig_d   = '0;
        end
      end
      ST_DRAIN: begin
        // Any pending result leaves through the normal handshake first, so
        // sweep results never mix with stream results on out_*.
        if (!out_valid_q) begin
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ core_result;
        // Counter wraps to zero after the last vector, ready for next sweep.
        cnt_d = cnt_q + CNT_W'(1);
        if (&cnt_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sig_q       <= '0;
      y_q         <= '0;
      y_zero_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      y_q         <= y_d;
      y_zero_q    <= y_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // in_ready is combinational; it is masked by rst so every output reads 0
  // while reset is held.
  assign in_ready   = accept_ok & ~rst;
  assign out_valid  = out_valid_q;
  assign y          = y_q;
  assign y_zero     = y_zero_q;
  assign sweep_busy = (state_q == ST_DRAIN) | (state_q == ST_SWEEP);
  assign sweep_done = (state_q == ST_DONE);
  assign sweep_sig  = sig_q;

endmodule : logic_gate_unit
